// File: rtl/spart_core.sv
// spart_core: SPART bus responder with baud generator, serial transmitter and receiver.
// Optional macro SPART_STATUS_ERR_EN: adds sticky framing-error (status bit2) and
// overrun (status bit3) flags, both cleared by a status read.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   iocs     bus chip select
//   iorw     1 = read (core drives databus), 0 = write
//   ioaddr   register select: 00 TX/RX data, 01 status, 10 divisor lo, 11 divisor hi
//   databus  shared bidirectional data bus, driven only on selected reads
//   rda      receive data available
//   tbr      transmit buffer ready
//   txd      serial transmit line, idle high
//   rxd      serial receive line, asynchronous to clk
module spart_core #(
    parameter logic [15:0] DIV_RESET = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      tx_state, rx_state;
    logic [15:0] divisor, cnt;
    logic [7:0]  tx_sh, rx_sh, rbuf, status, rdata;
    logic [3:0]  tx_tc, rx_tc;
    logic [2:0]  tx_bit, rx_bit;
    logic        wr, rd, tick, rx_s1, rx_s2, rx_prev, rx_mid, rx_done, rx_ferr;

    assign wr   = iocs && !iorw;
    assign rd   = iocs && iorw;
    assign tick = (cnt == 16'd0);

    // Baud counter; a divisor write reloads it with the freshly written value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor <= DIV_RESET;
            cnt     <= DIV_RESET;
        end else if (wr && ioaddr == 2'b10) begin
            divisor[7:0] <= databus;
            cnt          <= {divisor[15:8], databus};
        end else if (wr && ioaddr == 2'b11) begin
            divisor[15:8] <= databus;
            cnt           <= {databus, divisor[7:0]};
        end else begin
            cnt <= tick ? divisor : cnt - 16'd1;
        end
    end

    // Transmitter; tbr is high exactly while IDLE, so busy-time writes fall through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_sh    <= 8'h00;
            tx_tc    <= 4'd0;
            tx_bit   <= 3'd0;
            txd      <= 1'b1;
            tbr      <= 1'b1;
        end else if (tx_state == IDLE) begin
            if (wr && ioaddr == 2'b00) begin
                tx_state <= START;
                tx_sh    <= databus;
                tx_tc    <= 4'd0;
                txd      <= 1'b0;
                tbr      <= 1'b0;
            end
        end else if (tick) begin
            tx_tc <= tx_tc + 4'd1;
            if (tx_tc == 4'd15) begin
                case (tx_state)
                    START: begin
                        tx_state <= DATA;
                        tx_bit   <= 3'd0;
                        txd      <= tx_sh[0];
                        tx_sh    <= tx_sh >> 1;
                    end
                    DATA: begin
                        tx_bit <= tx_bit + 3'd1;
                        if (tx_bit == 3'd7) begin
                            tx_state <= STOP;
                            txd      <= 1'b1;
                        end else begin
                            txd   <= tx_sh[0];
                            tx_sh <= tx_sh >> 1;
                        end
                    end
                    default: begin
                        tx_state <= IDLE;
                        tbr      <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Mid-bit point: 8 ticks into the start bit, then every 16 ticks.
    assign rx_mid  = tick && (rx_tc == ((rx_state == START) ? 4'd7 : 4'd15));
    assign rx_done = (rx_state == STOP) && rx_mid && rx_s2;
    assign rx_ferr = (rx_state == STOP) && rx_mid && !rx_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_tc    <= 4'd0;
            rx_bit   <= 3'd0;
            rx_sh    <= 8'h00;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (rx_state == IDLE) begin
                rx_tc <= 4'd0;
                if (rx_prev && !rx_s2)
                    rx_state <= START;
            end else if (tick) begin
                rx_tc <= rx_mid ? 4'd0 : rx_tc + 4'd1;
                if (rx_mid) begin
                    case (rx_state)
                        START: begin
                            rx_state <= rx_s2 ? IDLE : DATA;
                            rx_bit   <= 3'd0;
                        end
                        DATA: begin
                            rx_sh  <= {rx_s2, rx_sh[7:1]};
                            rx_bit <= rx_bit + 3'd1;
                            if (rx_bit == 3'd7)
                                rx_state <= STOP;
                        end
                        default: rx_state <= IDLE;
                    endcase
                end
            end
        end
    end

    // A completing byte takes priority over the clearing read.
`ifdef SPART_STATUS_ERR_EN
    logic ferr, ovr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ferr <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            ferr <= rx_ferr || (ferr && !(rd && ioaddr == 2'b01));
            ovr  <= (rx_done && rda) || (ovr && !(rd && ioaddr == 2'b01));
        end
    end
    assign status = {4'b0, ovr, ferr, tbr, rda};
`else
    assign status = {6'b0, tbr, rda};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbuf <= 8'h00;
            rda  <= 1'b0;
        end else begin
            if (rx_done)
                rbuf <= rx_sh;
            rda <= rx_done || (rda && !(rd && ioaddr == 2'b00));
        end
    end

    always_comb
        rdata = (ioaddr == 2'b00) ? rbuf :
                (ioaddr == 2'b01) ? status :
                (ioaddr == 2'b10) ? divisor[7:0] : divisor[15:8];

    assign databus = rd ? rdata : 8'bz;
endmodule

// File: tb/tb_spart_core.sv
// tb_spart_core: randomized self-checking bench for spart_core against a frame-level model.
module tb_spart_core;
    logic       clk = 1'b0, rst = 1'b1, iocs = 1'b0, iorw = 1'b0, rxd = 1'b1;
    logic [1:0] ioaddr = 2'b00;
    logic       drv_en = 1'b0;
    logic [7:0] drv = 8'h00;
    wire  [7:0] databus;
    logic       rda, tbr, txd;

    assign databus = drv_en ? drv : 8'bz;

    spart_core dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
    );

    always #10 clk = ~clk;

    int errors = 0, checks = 0;
    bit mon = 1'b0, tx_active = 1'b0;
    bit m_rda = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
    logic [7:0]  m_rbuf = 8'h00;
    logic [15:0] m_div = 16'd325;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    function automatic logic [7:0] exp_status();
`ifdef SPART_STATUS_ERR_EN
        return {4'b0, m_ov, m_fe, ~tx_active, m_rda};
`else
        return {6'b0, ~tx_active, m_rda};
`endif
    endfunction

    // Per-cycle comparison against the model whenever the outputs are settled.
    always @(negedge clk) begin
        if (mon) begin
            check("rda_track", rda, m_rda);
            if (!tx_active) begin
                check("tbr_idle", tbr, 1);
                check("txd_idle", txd, 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv = d; drv_en = 1'b1;
        step();
        iocs = 1'b0; drv_en = 1'b0;
        if (a == 2'b10) m_div[7:0] = d;
        if (a == 2'b11) m_div[15:8] = d;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string name);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        @(negedge clk);
        check(name, databus, exp);
        if (a == 2'b00) check({name, "_rda_during"}, rda, m_rda);
        step();
        iocs = 1'b0; iorw = 1'b0;
        if (a == 2'b00) m_rda = 1'b0;
        if (a == 2'b01) begin m_fe = 1'b0; m_ov = 1'b0; end
    endtask

    // Transmit one byte, record txd each cycle until tbr returns, then decode.
    task automatic tx_frame(input logic [7:0] b, input bit drop);
        int d = int'(m_div) + 1;
        logic [9:0] f = {1'b1, b, 1'b0};
        logic q[$];
        int n = 0;
        tx_active = 1'b1;
        bus_write(2'b00, b);
        while (n < 170 * d + 20) begin
            if (drop && n == 1) begin iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; drv = 8'h3C; drv_en = 1'b1; end
            if (drop && n == 2) begin iocs = 1'b0; drv_en = 1'b0; end
            @(negedge clk);
            if (tbr) break;
            q.push_back(txd);
            n++;
        end
        check_range("tx_frame_len", n, 159 * d + 1, 160 * d);
        for (int k = 0; k < 10; k++)
            check("tx_bit", q[k * 16 * d + 8 * d], f[k]);
        if (b[0] && !b[1]) begin
            int z = 0, o = 0;
            while (z < q.size() && q[z] == 1'b0) z++;
            while (z + o < q.size() && q[z + o] == 1'b1) o++;
            check_range("tx_start_len", z, 15 * d + 1, 16 * d);
            check("tx_bit0_len", o, 16 * d);
        end
        step();
        tx_active = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop);
        int d = 16 * (int'(m_div) + 1);
        logic [9:0] f = {stop, b, 1'b0};
        mon = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rxd = f[k];
            repeat (d) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
        repeat (4) step();
        if (stop) begin
            m_ov = m_ov | m_rda;
            m_rbuf = b;
            m_rda = 1'b1;
        end else begin
            m_fe = 1'b1;
        end
        mon = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        mon = 1'b1;

        bus_read(2'b01, 8'h02, "status_reset");
        bus_read(2'b10, 8'h45, "div_lo_reset");
        bus_read(2'b11, 8'h01, "div_hi_reset");
        bus_read(2'b00, 8'h00, "rbuf_reset");

        iorw = 1'b0; ioaddr = 2'b10; drv = 8'hFF; drv_en = 1'b1;
        step();
        drv_en = 1'b0;
        bus_read(2'b10, 8'h45, "div_lo_no_cs");

        bus_write(2'b10, 8'h04);
        bus_write(2'b11, 8'h00);
        bus_read(2'b10, 8'h04, "div_lo_wr");
        bus_read(2'b11, 8'h00, "div_hi_wr");
        tx_frame(8'hA5, 1'b1);

        rx_frame(8'hC3, 1'b1);
        check("rda_after_rx", rda, 1);
        bus_read(2'b00, 8'hC3, "rbuf_c3");
        check("rda_cleared", rda, 0);

        rxd = 1'b0;
        repeat (10) step();
        rxd = 1'b1;
        repeat (120) step();
        check("rda_glitch", rda, 0);
        bus_read(2'b00, 8'hC3, "rbuf_glitch");

        rx_frame(8'h55, 1'b0);
        check("rda_ferr", rda, 0);
`ifdef SPART_STATUS_ERR_EN
        bus_read(2'b01, 8'h06, "status_ferr");
`else
        bus_read(2'b01, 8'h02, "status_ferr");
`endif
        bus_read(2'b01, 8'h02, "status_ferr_clr");
        bus_read(2'b00, 8'hC3, "rbuf_ferr");

        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
`ifdef SPART_STATUS_ERR_EN
        bus_read(2'b01, 8'h0B, "status_ovr");
`else
        bus_read(2'b01, 8'h03, "status_ovr");
`endif
        bus_read(2'b00, 8'h22, "rbuf_overrun");
        bus_read(2'b01, exp_status(), "status_ovr_clr");

        for (int it = 0; it < 6; it++) begin
            logic [7:0] dv, tb_byte, rb;
            bit st;
            dv = 8'($urandom_range(0, 5));
            tb_byte = 8'($urandom);
            rb = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            bus_write(2'b10, dv);
            bus_write(2'b11, 8'h00);
            bus_read(2'b10, m_div[7:0], "div_rand");
            tx_frame(tb_byte, 1'b0);
            rx_frame(rb, st);
            if ($urandom_range(0, 1) == 1) rx_frame(8'($urandom), 1'b1);
            bus_read(2'b01, exp_status(), "status_rand");
            bus_read(2'b00, m_rbuf, "rbuf_rand");
        end

        rx_frame(8'h77, 1'b1);
        mon = 1'b0;
        tx_active = 1'b1;
        bus_write(2'b00, 8'h00);
        repeat (100) step();
        check("txd_pre_rst", txd, 0);
        check("tbr_pre_rst", tbr, 0);
        check("rda_pre_rst", rda, 1);
        rst = 1'b1;
        #1;
        check("rst_txd", txd, 1);
        check("rst_tbr", tbr, 1);
        check("rst_rda", rda, 0);
        step();
        rst = 1'b0;
        m_rda = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_rbuf = 8'h00; m_div = 16'd325;
        tx_active = 1'b0;
        step();
        mon = 1'b1;
        bus_read(2'b10, 8'h45, "div_lo_rst2");
        bus_read(2'b11, 8'h01, "div_hi_rst2");
        bus_read(2'b01, 8'h02, "status_rst2");
        bus_read(2'b00, 8'h00, "rbuf_rst2");
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spart_core.md
Name: spart_core

Overview:
Peripheral (responder) side of the SPART processor bus: decodes iocs/iorw/ioaddr cycles issued by the bus master, owns the baud divisor registers, and implements the serial transmitter and receiver. Sits between the bus master and the board UART pins (txd/rxd). It presents rda/tbr status to the master and drives the shared databus only on read cycles.

Parameters:
DIV_RESET, 16'd325, divisor value loaded at reset (9600 baud at 50 MHz, 16x oversampling)

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  asynchronous, active-high reset
iocs  input  1  bus chip select; cycle valid when high
iorw  input  1  1 = read (core drives databus), 0 = write (master drives databus)
ioaddr  input  2  register select
databus  inout  8  shared data bus
rda  output  1  receive data available
tbr  output  1  transmit buffer ready
txd  output  1  serial transmit line, idle high
rxd  input  1  serial receive line, asynchronous to clk

Behaviour:
- Register map:
  - 00: write = TX data; read = RX buffer.
  - 01: read = status {6'b0, tbr, rda}; writes ignored.
  - 10: write/read = divisor[7:0].
  - 11: write/read = divisor[15:8].
- Databus is driven only while iocs && iorw; otherwise Hi-Z. Read data is combinational in the same cycle.
- Writes are captured at the posedge where iocs && !iorw.
- Reset values: txd=1, tbr=1, rda=0, RX buffer=8'h00, divisor=DIV_RESET, databus Hi-Z, TX/RX FSMs IDLE, baud counter=DIV_RESET.
- Baud generator:
  - 16-bit down-counter, reloaded with divisor on reaching 0; emits a 1-cycle tick on reaching 0. Tick period is divisor+1 clocks; one bit = 16 ticks.
  - Writing either divisor byte reloads the counter with the updated divisor on the next cycle.
  - divisor=0 gives a tick every clock.
- TX FSM (IDLE, START, DATA, STOP):
  - A write to 00 while tbr=1 loads the shift register; tbr=0 from the next cycle. A write to 00 while tbr=0 is dropped.
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit held 16 ticks.
  - tbr returns to 1 in the cycle after the stop bit's 16th tick.
- RX path: rxd passes through a 2-FF synchronizer. RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a 1->0 transition on the synchronized rxd enters START.
  - START: at tick 8, if rxd=1 it is a glitch and the FSM returns to IDLE; otherwise it proceeds.
  - DATA: samples each bit at its mid-bit point (every 16 ticks), LSB first.
  - STOP: samples at mid-bit. If stop=1, the byte loads the RX buffer and rda=1 next cycle. If stop=0 (framing error), the byte is discarded and rda is unchanged. The FSM returns to IDLE.
- rda clears at the clock edge ending a read of address 00, so the master sees rda=1 and valid data throughout the read cycle.
- Simultaneous events:
  - If a new byte completes in the same cycle as a read of 00, the new byte is loaded and rda stays 1 (set wins).
  - Overrun (byte completes while rda=1): the RX buffer is overwritten and rda stays 1.
- Reset mid-frame: both FSMs return to IDLE immediately and txd goes to 1. A partial RX frame is discarded.
- iocs=0: no register side effects regardless of iorw/ioaddr.

Optional Feature:
SPART_STATUS_ERR_EN
- Defined: status bit2 = framing-error sticky flag and bit3 = overrun sticky flag, each set by its event. Both clear at the end of a status (01) read; if an event coincides with that read, set wins. Framing-error bytes are still discarded.
- Undefined: status bits [7:2] read 0, no error flags are implemented, and error events are silent.

Test Plan:
1. Reset, then read 01 -> databus=8'h02 (tbr=1, rda=0). Read 10/11 -> 8'h45/8'h01.
2. Write divisor 10=8'h04, 11=8'h00, then write 00=8'hA5 -> tbr=0 next cycle. txd shows 0,1,0,1,0,0,1,0,1,1, each bit 80 clocks. tbr=1 after the stop bit.
3. Write 00=8'h3C while tbr=0 -> write dropped; the in-flight frame is unchanged.
4. Drive rxd with frame 8'hC3 at divisor 4 -> rda=1 and read 00 returns 8'hC3 with rda still 1 during the read; rda=0 the cycle after.
5. Drive a 2-tick low glitch on rxd -> no byte, rda stays 0. Drive frame 8'h55 with stop=0 -> rda stays 0; with SPART_STATUS_ERR_EN, status bit2=1, cleared after one status read.
6. Receive 8'h11 then 8'h22 without reading -> read 00 returns 8'h22, rda=1; with SPART_STATUS_ERR_EN, status bit3=1. Assert rst mid-TX -> txd=1 and tbr=1 immediately.
